// File: rtl/xbar_pkg.sv
// Shared definitions for the VOQ crossbar: arbitration modes, default entry layout
// and a constant-evaluable clog2 used to size pointers and counters.
package xbar_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam int DEF_ID_W   = 32;
    localparam int DEF_DATA_W = 64;

    // Reference layout of one queued beat; the top re-declares it with its own widths.
    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_DATA_W-1:0] data;
    } voq_entry_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/xbar_voq_fifo.sv
// First-word-fall-through queue holding one (input, output) pair's beats.
// Each push or pop is ignored if it would overflow or underflow the queue.
module xbar_voq_fifo
    import xbar_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 96
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Storage carries no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/xbar_voq_rr.sv
// NUM_IN x NUM_OUT crossbar: every input owns one queue per output, and every output
// arbitrates its column of queues into a registered valid/ready stage.
module xbar_voq_rr
    import xbar_pkg::*;
#(
    parameter int NUM_IN     = 64,
    parameter int NUM_OUT    = NUM_IN,
    parameter int ID_W       = 32,
    parameter int DATA_W     = 64,
    parameter int ID_LOW     = 20,
    parameter int FIFO_DEPTH = 16,
    parameter int ARB_MODE   = ARB_RR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN*ID_W-1:0]    din_id,
    input  logic [NUM_IN*DATA_W-1:0]  din_data,
    input  logic [NUM_IN-1:0]         din_valid,
    output logic [NUM_IN-1:0]         din_ready,
    input  logic                      drain_all,
    output logic [NUM_OUT*ID_W-1:0]   dout_id,
    output logic [NUM_OUT*DATA_W-1:0] dout_data,
    output logic [NUM_OUT-1:0]        dout_valid,
    input  logic [NUM_OUT-1:0]        dout_ready,
    output logic                      empty,
    output logic [15:0]               drop_cnt
);

    localparam int OUT_BITS = clog2(NUM_OUT);
    localparam int IN_BITS  = clog2(NUM_IN);
    localparam int DEST_W   = (OUT_BITS > 0) ? OUT_BITS : 1;
    localparam int IDX_W    = (IN_BITS > 0) ? IN_BITS : 1;
    localparam int CNT_W    = clog2(FIFO_DEPTH) + 1;
    localparam int NUM_Q    = NUM_IN * NUM_OUT;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             in_entry  [NUM_IN];
    logic [DEST_W-1:0]  dest      [NUM_IN];
    entry_t             q_head    [NUM_Q];
    logic [CNT_W-1:0]   q_count   [NUM_Q];
    logic [NUM_Q-1:0]   push_v;
    logic [NUM_Q-1:0]   pop_v;
    logic [NUM_Q-1:0]   full_v;
    logic [NUM_Q-1:0]   empty_v;
    logic [IN_BITS:0]   drop_n;
    logic [16:0]        drop_total;
    logic               voq_busy;

    logic [NUM_OUT-1:0] load;
    logic [NUM_OUT-1:0] grant_valid;
    logic [IDX_W-1:0]   grant_idx [NUM_OUT];
    entry_t             grant_entry [NUM_OUT];
    logic [IDX_W-1:0]   ptr [NUM_OUT];

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            in_entry[i].id   = din_id[i*ID_W +: ID_W];
            in_entry[i].data = din_data[i*DATA_W +: DATA_W];
        end
    end

    // Input steering: out-of-range destinations are always ready and only counted.
    always_comb begin : steer
        logic in_range;
        logic sel_full;
        push_v    = '0;
        drop_n    = '0;
        din_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (OUT_BITS == 0) begin
                dest[i] = '0;
            end else begin
                dest[i] = din_id[i*ID_W + ID_LOW +: DEST_W];
            end
            in_range = ({1'b0, dest[i]} < (DEST_W+1)'(NUM_OUT));
            sel_full = 1'b0;
            for (int j = 0; j < NUM_OUT; j++) begin
                if (dest[i] == DEST_W'(j)) begin
                    sel_full = full_v[i*NUM_OUT + j];
                end
            end
            din_ready[i] = rst & ~drain_all & (~in_range | ~sel_full);
            if (din_valid[i] && din_ready[i]) begin
                if (in_range) begin
                    for (int j = 0; j < NUM_OUT; j++) begin
                        if (dest[i] == DEST_W'(j)) begin
                            push_v[i*NUM_OUT + j] = 1'b1;
                        end
                    end
                end else begin
                    drop_n = drop_n + (IN_BITS+1)'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
            xbar_voq_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH ($bits(entry_t))
            ) u_voq (
                .clk   (clk),
                .rst   (rst),
                .push  (push_v[i*NUM_OUT + j]),
                .din   (in_entry[i]),
                .pop   (pop_v[i*NUM_OUT + j]),
                .dout  (q_head[i*NUM_OUT + j]),
                .full  (full_v[i*NUM_OUT + j]),
                .empty (empty_v[i*NUM_OUT + j]),
                .count (q_count[i*NUM_OUT + j])
            );
        end
    end

    assign load = ~dout_valid | dout_ready;

    // Per-output arbitration over its queue column; fixed mode always searches from 0.
    always_comb begin : arb
        int start;
        int idx;
        pop_v       = '0;
        grant_valid = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            grant_idx[j]   = '0;
            grant_entry[j] = '0;
            start = (ARB_MODE == ARB_RR) ? int'(ptr[j]) : 0;
            for (int k = 0; k < NUM_IN; k++) begin
                idx = start + k;
                if (idx >= NUM_IN) begin
                    idx = idx - NUM_IN;
                end
                if (!grant_valid[j] && !empty_v[idx*NUM_OUT + j]) begin
                    grant_valid[j] = 1'b1;
                    grant_idx[j]   = IDX_W'(idx);
                    grant_entry[j] = q_head[idx*NUM_OUT + j];
                end
            end
            if (grant_valid[j] && load[j]) begin
                pop_v[int'(grant_idx[j])*NUM_OUT + j] = 1'b1;
            end
        end
    end

    always_comb begin
        voq_busy = 1'b0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (q_count[q] != '0) begin
                voq_busy = 1'b1;
            end
        end
    end

    assign drop_total = {1'b0, drop_cnt} + 17'(drop_n);

    // Output registers, round-robin pointers, drop counter and the lagging empty flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_valid <= '0;
            dout_id    <= '0;
            dout_data  <= '0;
            drop_cnt   <= '0;
            empty      <= 1'b1;
            for (int j = 0; j < NUM_OUT; j++) begin
                ptr[j] <= '0;
            end
        end else begin
            drop_cnt <= (drop_total > 17'h0FFFF) ? 16'hFFFF : drop_total[15:0];
            empty    <= ~voq_busy & ~(|dout_valid);
            for (int j = 0; j < NUM_OUT; j++) begin
                if (load[j]) begin
                    dout_valid[j] <= grant_valid[j];
                    if (grant_valid[j]) begin
                        dout_id[j*ID_W +: ID_W]       <= grant_entry[j].id;
                        dout_data[j*DATA_W +: DATA_W] <= grant_entry[j].data;
                        if (ARB_MODE == ARB_RR) begin
                            ptr[j] <= (grant_idx[j] == IDX_W'(NUM_IN-1)) ? '0 : grant_idx[j] + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
